// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Looked up combinationally in IF, trained and checked in EX, with saturating perf counters.
module branch_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_if,
  output logic             pred_taken_if,
  output logic [XLEN-1:0]  pred_pc_if,
  input  logic             upd_valid_ex,
  input  logic [XLEN-1:0]  upd_pc_ex,
  input  logic             upd_taken_ex,
  input  logic [XLEN-1:0]  upd_target_ex,
  input  logic             pred_taken_ex,
  input  logic [XLEN-1:0]  pred_pc_ex,
  input  logic             stall,
  output logic             mispredict_ex,
  output logic [XLEN-1:0]  redirect_pc_ex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

  // Table state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  // Direction is implied by pred_pc_ex, so the carried bit is not needed.
  logic unused_pred_taken_ex;
  assign unused_pred_taken_ex = pred_taken_ex;

  // ---------------------------------------------------------------------------
  // IF lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_if;
  logic [TAG_W-1:0] tag_if;
  logic             hit_if;
  logic [XLEN-1:0]  seq_pc_if;

  always_comb begin
    idx_if        = pc_if[IDX_W+1:2];
    tag_if        = pc_if[TAG_HI:TAG_LO];
    seq_pc_if     = pc_if + XLEN'(4);
    hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    pred_taken_if = hit_if && ctr_q[idx_if][1];
    pred_pc_if    = pred_taken_if ? target_q[idx_if] : seq_pc_if;
  end

  // ---------------------------------------------------------------------------
  // EX check
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_ex;
  logic [TAG_W-1:0] tag_ex;
  logic             hit_ex;
  logic [XLEN-1:0]  seq_pc_ex;
  logic             train_en;

  always_comb begin
    idx_ex         = upd_pc_ex[IDX_W+1:2];
    tag_ex         = upd_pc_ex[TAG_HI:TAG_LO];
    seq_pc_ex      = upd_pc_ex + XLEN'(4);
    hit_ex         = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
    redirect_pc_ex = upd_taken_ex ? upd_target_ex : seq_pc_ex;
    // Comparing full next-PCs also flags a stale target with the right direction.
    mispredict_ex  = upd_valid_ex && (pred_pc_ex != redirect_pc_ex);
    train_en       = upd_valid_ex && !stall;
  end

  // ---------------------------------------------------------------------------
  // EX training: next-state of the addressed entry only
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (train_en) begin
      if (hit_ex) begin
        if (upd_taken_ex) begin
          target_d[idx_ex] = upd_target_ex;
          if (ctr_q[idx_ex] != 2'b11) begin
            ctr_d[idx_ex] = ctr_q[idx_ex] + 2'b01;
          end
        end else if (ctr_q[idx_ex] != 2'b00) begin
          ctr_d[idx_ex] = ctr_q[idx_ex] - 2'b01;
        end
      end else if (upd_taken_ex) begin
        valid_d[idx_ex]  = 1'b1;
        tag_d[idx_ex]    = tag_ex;
        target_d[idx_ex] = upd_target_ex;
        ctr_d[idx_ex]    = 2'b10;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (train_en) begin
      if (branch_cnt_q != {CNT_W{1'b1}}) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (mispredict_ex && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  // ---------------------------------------------------------------------------
  // State registers; reset also discards any update presented that cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q          <= valid_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic,
// checked against a table-of-entries reference model.
module tb_branch_predictor;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  pc_if;
  logic             pred_taken_if;
  logic [XLEN-1:0]  pred_pc_if;
  logic             upd_valid_ex;
  logic [XLEN-1:0]  upd_pc_ex;
  logic             upd_taken_ex;
  logic [XLEN-1:0]  upd_target_ex;
  logic             pred_taken_ex;
  logic [XLEN-1:0]  pred_pc_ex;
  logic             stall;
  logic             mispredict_ex;
  logic [XLEN-1:0]  redirect_pc_ex;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_predictor #(
    .XLEN   (XLEN),
    .ENTRIES(ENTRIES),
    .TAG_W  (TAG_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_if         (pc_if),
    .pred_taken_if (pred_taken_if),
    .pred_pc_if    (pred_pc_if),
    .upd_valid_ex  (upd_valid_ex),
    .upd_pc_ex     (upd_pc_ex),
    .upd_taken_ex  (upd_taken_ex),
    .upd_target_ex (upd_target_ex),
    .pred_taken_ex (pred_taken_ex),
    .pred_pc_ex    (pred_pc_ex),
    .stall         (stall),
    .mispredict_ex (mispredict_ex),
    .redirect_pc_ex(redirect_pc_ex),
    .branch_cnt    (branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ptk;
    logic [31:0] ppc;
    logic        misp;
    logic [31:0] rpc;
    int          bc;
    int          mc;
    bit          c_pred;
    bit          c_misp;
    bit          c_cnt;
    logic        cptk;
    logic [31:0] cppc;
    logic        cmisp;
    logic [31:0] crpc;
    int          cbc;
    int          cmc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: one record per BTB slot, plain integers for counters.
  bit          m_valid [16];
  int          m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_bc;
  int          m_mc;

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
  endfunction

  function automatic bit model_hit(logic [31:0] pc);
    int s = slot_of(pc);
    return m_valid[s] && (m_tag[s] == tag_of(pc));
  endfunction

  function automatic logic [31:0] model_next_pc(logic [31:0] pc);
    int s = slot_of(pc);
    if (model_hit(pc) && m_ctr[s] >= 2) return m_tgt[s];
    return pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic drive(input logic [31:0] pif, input logic uv, input logic [31:0] upc,
                       input logic tk, input logic [31:0] tgt, input logic [31:0] ppc,
                       input logic st, input logic rs);
    exp_t e;
    logic [31:0] act;
    int s;
    @(posedge clk);
    #1;
    rst           = rs;
    pc_if         = pif;
    upd_valid_ex  = uv;
    upd_pc_ex     = upc;
    upd_taken_ex  = tk;
    upd_target_ex = tgt;
    pred_pc_ex    = ppc;
    pred_taken_ex = (ppc != upc + 32'd4);
    stall         = st;
    act     = tk ? tgt : upc + 32'd4;
    e       = '{default: '0};
    e.ppc   = model_next_pc(pif);
    e.ptk   = (e.ppc != pif + 32'd4) || (model_hit(pif) && m_ctr[slot_of(pif)] >= 2);
    e.rpc   = act;
    e.misp  = uv && (ppc != act);
    e.bc    = m_bc;
    e.mc    = m_mc;
    exp_q.push_back(e);
    if (rs) begin
      model_reset();
    end else if (uv && !st) begin
      m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
      if (e.misp) m_mc = (m_mc < CNT_MAX) ? m_mc + 1 : CNT_MAX;
      s = slot_of(upc);
      if (model_hit(upc)) begin
        if (tk) begin
          m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = tgt;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (tk) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = tag_of(upc);
        m_tgt[s]   = tgt;
        m_ctr[s]   = 2;
      end
    end
  endtask

  task automatic lookup(input logic [31:0] pif);
    drive(pif, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0);
  endtask

  // Pin hand-derived values onto the cycle just driven.
  task automatic note_pred(input logic tk, input logic [31:0] pc);
    exp_q[$].c_pred = 1'b1;
    exp_q[$].cptk   = tk;
    exp_q[$].cppc   = pc;
  endtask

  task automatic note_misp(input logic m, input logic [31:0] rpc);
    exp_q[$].c_misp = 1'b1;
    exp_q[$].cmisp  = m;
    exp_q[$].crpc   = rpc;
  endtask

  task automatic note_cnt(input int b, input int m);
    exp_q[$].c_cnt = 1'b1;
    exp_q[$].cbc   = b;
    exp_q[$].cmc   = m;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, got, want);
    end
  endtask

  // Monitor: combinational outputs are presented every cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pred_taken_if", 32'(pred_taken_if), 32'(e.ptk));
      chk("pred_pc_if", pred_pc_if, e.ppc);
      chk("mispredict_ex", 32'(mispredict_ex), 32'(e.misp));
      chk("redirect_pc_ex", redirect_pc_ex, e.rpc);
      chk("branch_cnt", 32'(branch_cnt), 32'(e.bc));
      chk("mispredict_cnt", 32'(mispredict_cnt), 32'(e.mc));
      if (e.c_pred) begin
        chk("dir_pred_taken", 32'(pred_taken_if), 32'(e.cptk));
        chk("dir_pred_pc", pred_pc_if, e.cppc);
      end
      if (e.c_misp) begin
        chk("dir_mispredict", 32'(mispredict_ex), 32'(e.cmisp));
        chk("dir_redirect", redirect_pc_ex, e.crpc);
      end
      if (e.c_cnt) begin
        chk("dir_branch_cnt", 32'(branch_cnt), 32'(e.cbc));
        chk("dir_mispredict_cnt", 32'(mispredict_cnt), 32'(e.cmc));
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    return 32'($urandom_range(0, 3) * 32'h400 + $urandom_range(0, 15) * 4);
  endfunction

  initial begin
    logic [31:0] upc;
    logic        tk;
    int          drain;
    rst = 1'b1; pc_if = '0; upd_valid_ex = 1'b0; upd_pc_ex = '0; upd_taken_ex = 1'b0;
    upd_target_ex = '0; pred_taken_ex = 1'b0; pred_pc_ex = '0; stall = 1'b0;
    model_reset();

    // 1: reset then cold lookup
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b1);
    lookup(32'h40);
    note_pred(1'b0, 32'h44); note_cnt(0, 0);

    // 2: cold taken branch allocates; prediction visible next cycle
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 32'h44, 1'b0, 1'b0);
    note_misp(1'b1, 32'h100); note_pred(1'b0, 32'h44);
    lookup(32'h40);
    note_pred(1'b1, 32'h100); note_cnt(1, 1);

    // 3: saturate, then one not-taken keeps taken, second flips
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 32'h100, 1'b0, 1'b0);
      note_misp(1'b0, 32'h100);
    end
    drive(32'h0, 1'b1, 32'h40, 1'b0, 32'h100, 32'h100, 1'b0, 1'b0);
    note_misp(1'b1, 32'h44);
    lookup(32'h40);
    note_pred(1'b1, 32'h100);
    drive(32'h0, 1'b1, 32'h40, 1'b0, 32'h100, 32'h100, 1'b0, 1'b0);
    lookup(32'h40);
    note_pred(1'b0, 32'h44); note_cnt(6, 3);

    // 4: alias at index 0 with a different tag replaces the entry
    drive(32'h0, 1'b1, 32'h440, 1'b1, 32'h200, 32'h444, 1'b0, 1'b0);
    lookup(32'h40);
    note_pred(1'b0, 32'h44);
    lookup(32'h440);
    note_pred(1'b1, 32'h200); note_cnt(7, 4);

    // 5a: same-index lookup and update: old entry this cycle, new one next
    drive(32'h440, 1'b1, 32'h440, 1'b0, 32'h0, 32'h200, 1'b0, 1'b0);
    note_pred(1'b1, 32'h200); note_misp(1'b1, 32'h444);
    lookup(32'h440);
    note_pred(1'b0, 32'h444); note_cnt(8, 5);
    // 5b: stalled update checks but neither trains nor counts
    drive(32'h440, 1'b1, 32'h440, 1'b1, 32'h300, 32'h444, 1'b1, 1'b0);
    note_misp(1'b1, 32'h300);
    lookup(32'h440);
    note_pred(1'b0, 32'h444); note_cnt(8, 5);

    // 6: counters saturate, then reset clears everything
    for (int i = 0; i < 20; i++) begin
      drive(32'h0, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    lookup(32'h40);
    note_cnt(15, 15);
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 32'h44, 1'b0, 1'b1);
    lookup(32'h40);
    note_pred(1'b0, 32'h44); note_cnt(0, 0);

    // Random traffic over a few aliasing PCs
    for (int i = 0; i < 2000; i++) begin
      upc = rand_pc();
      tk  = 1'($urandom_range(0, 1));
      drive(rand_pc(), 1'($urandom_range(0, 3) != 0), upc, tk,
            32'($urandom_range(0, 255) * 4),
            ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255) * 4) : model_next_pc(upc),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 199) == 0));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
